pulse_share_ctrl: RTL
=====================

# pulse_share_ctrl

Controller that shares the single 2-bit pulse-length classifier (Mealy FSM: serial input `b`, code output `y`, synchronous state register) among four serial requesters. It round-robin arbitrates the requesters, muxes the granted line onto the classifier input, and captures the classifier's end-of-pulse code. It forces termination of over-long pulses and delivers each result with its channel number over a valid/ready handshake. The block sits between the input channels and the classifier instance; the classifier itself is not modified.

## Interface
- `MAX_LEN`, 15: maximum measured pulse length in cycles before forced termination; legal range 3..255.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: per-channel request; held high while the channel has a pulse to classify.
- `din` input 4: per-channel serial data.
- `grant` output 4: one-hot grant, registered; all zero when no channel is granted.
- `cls_b` output 1: drives the classifier `b` input (combinational mux of `din[gch]`, gated by state).
- `cls_rst` output 1: drives the classifier reset.
- `cls_y` input 2: classifier code; 00 = none, 11 = short (1 cycle), 10 = medium (2 cycles), 01 = long (≥3 cycles).
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.
- `res_code` output 2: captured classifier code.
- `res_ch` output 2: channel that produced the result.

## Operation
- States: IDLE, ARMED, MEASURE, OUT. Reset state is IDLE.
- Reset values: `grant`=0, `res_valid`=0, `res_code`=0, `res_ch`=0, `len`=0, `last`=3. This makes channel 0 the first priority.
- `cls_rst`=1 in IDLE and OUT, and while `rst` is high; 0 otherwise.
- `cls_b`=0 in IDLE and OUT.
- IDLE:
  - If `req`≠0, select the first requesting channel searching `last+1, last+2, ...` modulo 4.
  - Register `gch`, set `grant` one-hot, go to ARMED.
- ARMED:
  - `cls_b = din[gch]`.
  - If `req[gch]`=0, clear `grant` and go to IDLE. No result is produced and `last` is unchanged.
  - Otherwise, if `din[gch]`=1, set `len`=1 and go to MEASURE.
- MEASURE:
  - `cls_b = din[gch]`, except when `len`=MAX_LEN, where `cls_b` is forced to 0 (forced termination).
  - If `cls_y`≠00, capture `res_code`=`cls_y` and `res_ch`=`gch`, set `res_valid`=1, go to OUT.
  - Otherwise increment `len`.
  - `req[gch]` is ignored in MEASURE; a started pulse always completes.
- OUT:
  - Hold `res_valid`, `res_code`, `res_ch` stable until `res_valid && res_ready`.
  - On the handshake: `res_valid`=0, `last`=`gch`, `grant`=0, go to IDLE.
- `len` width is ceil(log2(MAX_LEN+1)). It never exceeds MAX_LEN.
- Asynchronous reset in any state, including mid-pulse or with a result pending: return to IDLE immediately and discard the result.

## Timing
- Arbitration latency: `req` sampled high in IDLE at edge k gives `grant` high after edge k.
- Pulse rising on `din` in ARMED cycle t, lasting L cycles (falling in cycle t+L):
  - `cls_y`≠0 during cycle t+L.
  - `res_valid` high from cycle t+L+1.
- Forced termination happens in cycle t+MAX_LEN. Its code is always 01.
- Minimum turnaround: one result every 4 cycles for single-cycle pulses (IDLE, ARMED, MEASURE, OUT), with `res_ready` tied high.
- `res_ready` may be high before `res_valid`. Transfer occurs on the first edge where both are high.
- Simultaneous requests at arbitration: exactly one grant. Priority rotates strictly after each delivered result.

## Structure
- Shared package `pulse_pkg`:
  - State enum.
  - Code constants `CODE_NONE`=00, `CODE_LONG`=01, `CODE_MED`=10, `CODE_SHORT`=11.
  - Channel count constant 4.
- Natural sub-module `rr_arb4`: combinational 4-way round-robin picker. Inputs: `req`, `last`. Outputs: `gch`, `any`.
- Classifier instance lives one level up, wired to `cls_b`, `cls_rst`, `cls_y`.

## Test plan
- Reset, then `req`=0001 and a 1-cycle pulse on `din[0]`: `grant`=0001 one cycle after `req`; result `res_ch`=0, `res_code`=11; `res_valid` one cycle after `din` falls.
- `req`=1111 held, 2-cycle pulses on every channel, `res_ready`=1: results in channel order 0,1,2,3,0, each `res_code`=10.
- `MAX_LEN`=15, `din[2]` held high 40 cycles: `cls_b` forced 0 in the 15th MEASURE cycle; result `res_ch`=2, `res_code`=01; `res_valid` at pulse start +16.
- `req[1]` dropped in ARMED with no pulse: `grant`→0, no `res_valid`; next grant search starts from channel 0 (`last` unchanged).
- `res_ready`=0 for 10 cycles in OUT: `res_valid`/`res_code`/`res_ch` stable, `grant` held, other `req` not granted; after `res_ready`=1, next channel is granted.
- `rst` pulsed mid-MEASURE and again in OUT: all outputs return to reset values asynchronously; the next arbitration selects channel 0 first.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse classifier sharing controller.
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_LONG  = 2'b01;
    localparam logic [1:0] CODE_MED   = 2'b10;
    localparam logic [1:0] CODE_SHORT = 2'b11;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    endfunction

endpackage

// File: rtl/pulse_share_ctrl_rr_arb4.sv
// Combinational 4-way round-robin picker: first requester after `last`, wrapping.
module rr_arb4
    import pulse_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   gch,
    output logic              any
);

    logic [CH_W-1:0] idx;

    always_comb begin
        gch = '0;
        any = 1'b0;
        idx = '0;
        // Search last+1 .. last+4 so the most recently served channel is checked last.
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last + CH_W'(i);
            if (!any && req[idx]) begin
                gch = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_share_ctrl.sv
// Shares one pulse-length classifier among four serial requesters with round-robin
// arbitration, forced termination of over-long pulses and a valid/ready result port.
module pulse_share_ctrl
    import pulse_pkg::*;
#(
    parameter int MAX_LEN = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] din,
    output logic [NUM_CH-1:0] grant,
    output logic              cls_b,
    output logic              cls_rst,
    input  logic [1:0]        cls_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_code,
    output logic [CH_W-1:0]   res_ch
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [CH_W-1:0]   gch_q, gch_d;
    logic [CH_W-1:0]   last_q, last_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              res_valid_q, res_valid_d;
    logic [1:0]        res_code_q, res_code_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;

    logic [CH_W-1:0]   arb_gch;
    logic              arb_any;

    rr_arb4 u_arb (
        .req  (req),
        .last (last_q),
        .gch  (arb_gch),
        .any  (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gch_d       = gch_q;
        last_d      = last_q;
        len_d       = len_q;
        res_valid_d = res_valid_q;
        res_code_d  = res_code_q;
        res_ch_d    = res_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gch_d   = arb_gch;
                    grant_d = ch_onehot(arb_gch);
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!req[gch_q]) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (din[gch_q]) begin
                    len_d   = LEN_W'(1);
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // A started pulse always runs to completion; req is not consulted here.
                if (cls_y != CODE_NONE) begin
                    res_code_d  = cls_y;
                    res_ch_d    = gch_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (len_q != LEN_MAX) begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    last_d      = gch_q;
                    grant_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gch_q       <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            len_q       <= '0;
            res_valid_q <= 1'b0;
            res_code_q  <= CODE_NONE;
            res_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gch_q       <= gch_d;
            last_q      <= last_d;
            len_q       <= len_d;
            res_valid_q <= res_valid_d;
            res_code_q  <= res_code_d;
            res_ch_q    <= res_ch_d;
        end
    end

    // Forcing b low at MAX_LEN makes the classifier report its end-of-pulse code.
    always_comb begin
        cls_b = 1'b0;
        if (state_q == ST_ARMED) begin
            cls_b = din[gch_q];
        end else if (state_q == ST_MEASURE) begin
            cls_b = (len_q == LEN_MAX) ? 1'b0 : din[gch_q];
        end
    end

    assign cls_rst   = rst || (state_q == ST_IDLE) || (state_q == ST_OUT);
    assign grant     = grant_q;
    assign res_valid = res_valid_q;
    assign res_code  = res_code_q;
    assign res_ch    = res_ch_q;

endmodule
